// File: rtl/sha_pkg.sv
// Shared SHA definitions: default widths, digest type and serializer FSM states.
package sha_pkg;

    localparam int unsigned DIGEST_W_DEF = 256;
    localparam int unsigned WORD_W_DEF   = 32;
    localparam int unsigned CNT_W_DEF    = 16;

    typedef logic [DIGEST_W_DEF-1:0] digest_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } ser_state_t;

    // Index width for n words, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sha_digest_serializer_if.sv
// Digest-in / word-out handshake bundle between the SHA core, the serializer and its consumer.
interface sha_digest_serializer_if #(
    parameter int unsigned DIGEST_W = 256,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned CNT_W    = 16
);
    logic [DIGEST_W-1:0] hash_data;
    logic                hash_valid;
    logic                hash_rdy;
    logic [WORD_W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [CNT_W-1:0]    digest_cnt;

    // Environment view: supplies digests and consumes words.
    modport master (
        output hash_data, hash_valid, out_ready,
        input  hash_rdy, out_data, out_valid, out_last, digest_cnt
    );

    // Serializer view.
    modport slave (
        input  hash_data, hash_valid, out_ready,
        output hash_rdy, out_data, out_valid, out_last, digest_cnt
    );
endinterface

// File: rtl/sha_digest_serializer.sv
// Accepts a whole digest and streams it out MS word first, with a last flag and a
// wrapping count of fully delivered digests.
module sha_digest_serializer
    import sha_pkg::*;
#(
    parameter int unsigned DIGEST_W = DIGEST_W_DEF,
    parameter int unsigned WORD_W   = WORD_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sha_digest_serializer_if.slave  bus
);

    localparam int unsigned NWORDS = DIGEST_W / WORD_W;
    localparam int unsigned IDX_W  = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    ser_state_t          r_state, w_state_d;
    logic [DIGEST_W-1:0] r_shift, w_shift_d;
    logic [IDX_W-1:0]    r_idx,   w_idx_d;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_d;

    logic w_out_valid;
    logic w_out_last;
    logic w_beat;
    logic w_done;
    logic w_hash_rdy;
    logic w_load;

    // Handshake decode; hash_rdy deliberately sees out_ready combinationally so a new
    // digest can load on the final beat without a bubble.
    always_comb begin
        w_out_valid = (r_state == StSend);
        w_out_last  = w_out_valid && (r_idx == LAST_IDX);
        w_beat      = w_out_valid && bus.out_ready;
        w_done      = w_beat && w_out_last;
        w_hash_rdy  = (r_state == StIdle) || w_done;
        w_load      = bus.hash_valid && w_hash_rdy;
    end

    // Next state: shift on each accepted beat, reload on capture (capture wins on the last beat).
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_idx_d   = r_idx;
        w_cnt_d   = r_cnt;

        if (w_beat) begin
            w_shift_d = r_shift << WORD_W;
            w_idx_d   = r_idx + IDX_W'(1);
        end
        if (w_done) begin
            w_cnt_d   = r_cnt + CNT_W'(1);
            w_state_d = StIdle;
        end
        if (w_load) begin
            w_shift_d = bus.hash_data;
            w_idx_d   = '0;
            w_state_d = StSend;
        end
    end

    // State register; reset discards any partially sent digest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_idx   <= w_idx_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Output mapping; out_data is the top word of the shift register.
    always_comb begin
        bus.hash_rdy   = w_hash_rdy;
        bus.out_valid  = w_out_valid;
        bus.out_last   = w_out_last;
        bus.out_data   = r_shift[DIGEST_W-1 -: WORD_W];
        bus.digest_cnt = r_cnt;
    end

endmodule

// File: doc/sha_digest_serializer.md
Name: sha_digest_serializer

Overview:
Consumer stage directly downstream of the SHA core's hash output port. Accepts one 256-bit digest per hash_valid/hash_rdy handshake and emits it as a stream of WORD_W-bit words, most significant word first, on a valid/ready output with a last flag. Feeds the result FIFO/UART/bus-writer logic. Also keeps a free-running count of digests fully delivered.

Parameters:
DIGEST_W, 256, digest width in bits; must be an integer multiple of WORD_W.
WORD_W, 32, output word width in bits.
CNT_W, 16, width of the delivered-digest counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
hash_data  input  DIGEST_W  digest from SHA core, valid when hash_valid=1
hash_valid  input  1  SHA core has a digest available
hash_rdy  output  1  serializer can accept a digest this cycle
out_data  output  WORD_W  current output word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts word this cycle
out_last  output  1  current word is the final (least significant) word of the digest
digest_cnt  output  CNT_W  number of digests whose last word has been accepted

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state clears immediately on rst_n=0; release is synchronous to clk.
- Reset values: hash_rdy=1 (combinational, reflects IDLE), out_valid=0, out_last=0, out_data=0, digest_cnt=0, state=IDLE, word index=0.
- NWORDS = DIGEST_W/WORD_W (8 by default); word index width = clog2(NWORDS), minimum 1.
- States: IDLE, SEND.
- IDLE: hash_rdy=1, out_valid=0. On hash_valid=1, capture hash_data into a shift register, set index=0, go to SEND. out_valid rises the cycle after capture (1-cycle latency).
- SEND: out_valid=1; out_data = upper WORD_W bits of the shift register; out_last=1 when index=NWORDS-1. On out_valid&out_ready, shift left by WORD_W and increment index. out_data/out_valid/out_last remain stable while out_ready=0.
- Last beat (out_last&out_ready): digest_cnt increments. hash_rdy=1 combinationally in this cycle. If hash_valid=1 as well, load the new digest, reset index=0, stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- hash_rdy = (state==IDLE) | (out_valid & out_ready & out_last). This is the only combinational input-to-output path and is required.
- hash_rdy=0 at all other times in SEND. The upstream digest is held by the SHA core per its valid/rdy contract.
- digest_cnt wraps modulo 2^CNT_W; it does not saturate.
- Reset mid-SEND: the partial digest is discarded, out_valid drops asynchronously, and the block returns to IDLE. No resumption.
- hash_valid while hash_rdy=0: ignored; no capture.
- out_ready asserted while out_valid=0: no effect.

Decomposition:
- Shared package sha_pkg holds DIGEST_W_DEF=256, WORD_W_DEF=32, and the typedef digest_t (logic [255:0]) for reuse by the SHA core and the benches.
- Single flat module; no sub-module needed. The shift register, index counter and FSM fit in roughly 150 lines.

Test Plan:
- Single digest, out_ready held 1: hash_data=0x00010203…1c1d1e1f -> 8 consecutive beats 0x00010203, 0x04050607, …, 0x1c1d1e1f, starting the cycle after capture; out_last only on beat 8; digest_cnt=1; hash_rdy back to 1.
- Backpressure: same digest, out_ready toggled 1,0,0,1,… -> each word held stable while out_ready=0; word order unchanged; exactly 8 accepted beats.
- Back-to-back: hash_valid held with digests A then B, out_ready=1 -> 16 contiguous beats with no bubble; hash_rdy pulses high only on A's last beat; digest_cnt=2.
- Reset mid-stream: assert rst_n=0 after beat 3 -> out_valid=0 immediately; after release hash_rdy=1, digest_cnt=0; a new digest serializes from word 0.
- Counter wrap with CNT_W=2: deliver 5 digests -> digest_cnt sequence 1,2,3,0,1.
- WORD_W=64: digest 0x0011…ff (32 bytes) -> 4 beats, MS 64 bits first; out_last on beat 4.
